// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer
// ----------------------------------------------------------------------------
// Hardwired control unit for the DataPath. It sequences the fetch steps
// (T0-T2) and the R-format execute steps (T3-T6) and drives the DataPath
// control inputs (bus selects, load enables, ALU opcode, memory read) from
// the registered state and the current IR contents.
//
// Optional feature (macro SEQ_STEP_EN):
//   defined   : adds input i_step. The END state holds until a rising edge
//               on i_step, which gives one instruction per step.
//   undefined : no i_step port; END always lasts exactly one cycle.
//
// Parameters
//   NREG  number of general registers (width of o_s_R / o_e_R)
//   OPW   width of o_alu_op (must be >= 5)
//
// Ports
//   w_clock      in   1     system clock, rising-edge
//   w_clear      in   1     synchronous active-low reset
//   i_run        in   1     keep fetching/executing while high
//   i_mem_ready  in   1     memory data valid, sampled in T1
//   i_step       in   1     (SEQ_STEP_EN only) single-step request
//   i_IR         in   32    IR: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   o_s_PC/o_s_Zlow/o_s_Zhigh/o_s_MDR  out 1    bus source selects
//   o_s_R        out  NREG  one-hot register bus select
//   o_e_R        out  NREG  one-hot register write enable
//   o_e_MAR/o_e_Z/o_e_PC/o_e_MDR/o_e_IR/o_e_Y/o_e_HI/o_e_LO/o_e_alu
//                out  1     load enables
//   o_IncPC      out  1     ALU computes PC+1 (T0)
//   o_read       out  1     memory read strobe
//   o_alu_op     out  OPW   {0, op} in T4, zero otherwise
//   o_busy       out  1     high in every state except IDLE
//   o_done       out  1     pulse in the last execute state
//   o_illegal    out  1     pulse in T3 for ops 13..31
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int NREG = 16,
   parameter int OPW  = 6
) (
   input  logic              w_clock,
   input  logic              w_clear,
   input  logic              i_run,
   input  logic              i_mem_ready,
`ifdef SEQ_STEP_EN
   input  logic              i_step,
`endif
   input  logic [31:0]       i_IR,
   output logic              o_s_PC,
   output logic              o_s_Zlow,
   output logic              o_s_Zhigh,
   output logic              o_s_MDR,
   output logic [NREG-1:0]   o_s_R,
   output logic [NREG-1:0]   o_e_R,
   output logic              o_e_MAR,
   output logic              o_e_Z,
   output logic              o_e_PC,
   output logic              o_e_MDR,
   output logic              o_e_IR,
   output logic              o_e_Y,
   output logic              o_e_HI,
   output logic              o_e_LO,
   output logic              o_e_alu,
   output logic              o_IncPC,
   output logic              o_read,
   output logic [OPW-1:0]    o_alu_op,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_illegal
);

   // ------------------------------------------------------------------------
   // Opcode map
   // ------------------------------------------------------------------------
   localparam logic [4:0] OP_NOT       = 5'd4;
   localparam logic [4:0] OP_MUL       = 5'd5;
   localparam logic [4:0] OP_DIV       = 5'd6;
   localparam logic [4:0] OP_NEG       = 5'd12;
   localparam logic [4:0] OP_LAST_LEGAL = 5'd12;

   // ------------------------------------------------------------------------
   // State encoding. T1 is split in two so the PC load happens only on the
   // first T1 cycle while the outputs still come purely from the state.
   // ------------------------------------------------------------------------
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T1W   = 4'd3,
      ST_T2    = 4'd4,
      ST_T3    = 4'd5,
      ST_T4    = 4'd6,
      ST_T5    = 4'd7,
      ST_T6    = 4'd8,
      ST_END   = 4'd9
   } state_t;

   state_t state_q;
   state_t state_d;

   // ------------------------------------------------------------------------
   // IR field decode
   // ------------------------------------------------------------------------
   logic [4:0] op_w;
   logic [3:0] ra_w;
   logic [3:0] rb_w;
   logic [3:0] rc_w;
   logic       op_legal_w;
   logic       op_unary_w;
   logic       op_muldiv_w;
   logic       unused_ir_bits;

   assign op_w        = i_IR[31:27];
   assign ra_w        = i_IR[26:23];
   assign rb_w        = i_IR[22:19];
   assign rc_w        = i_IR[18:15];
   assign op_legal_w  = (op_w <= OP_LAST_LEGAL);
   assign op_unary_w  = (op_w == OP_NOT) || (op_w == OP_NEG);
   assign op_muldiv_w = (op_w == OP_MUL) || (op_w == OP_DIV);

   // Low IR bits carry no information for R-format control.
   assign unused_ir_bits = ^i_IR[14:0];

   // ------------------------------------------------------------------------
   // END-state release condition
   // ------------------------------------------------------------------------
   logic end_release_w;

`ifdef SEQ_STEP_EN
   logic step_q;

   // Edge history of i_step; a level held high across several instructions
   // must not release more than one of them.
   always_ff @(posedge w_clock) begin
      if (!w_clear) begin
         step_q <= 1'b0;
      end else begin
         step_q <= i_step;
      end
   end

   assign end_release_w = i_step && !step_q;
`else
   assign end_release_w = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge w_clock) begin
      if (!w_clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_run) begin
               state_d = ST_T0;
            end
         end
         ST_T0: begin
            state_d = ST_T1;
         end
         ST_T1, ST_T1W: begin
            state_d = i_mem_ready ? ST_T2 : ST_T1W;
         end
         ST_T2: begin
            state_d = ST_T3;
         end
         ST_T3: begin
            state_d = op_legal_w ? ST_T4 : ST_END;
         end
         ST_T4: begin
            state_d = ST_T5;
         end
         ST_T5: begin
            state_d = op_muldiv_w ? ST_T6 : ST_END;
         end
         ST_T6: begin
            state_d = ST_END;
         end
         ST_END: begin
            // i_run is only consulted here, so dropping it mid-instruction
            // lets the instruction complete.
            if (end_release_w) begin
               state_d = i_run ? ST_T0 : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode (Moore: state plus the IR held by the DataPath)
   // ------------------------------------------------------------------------
   logic       s_r_en;
   logic [3:0] s_r_idx;
   logic       e_r_en;
   logic [3:0] e_r_idx;

   always_comb begin
      o_s_PC    = 1'b0;
      o_s_Zlow  = 1'b0;
      o_s_Zhigh = 1'b0;
      o_s_MDR   = 1'b0;
      o_e_MAR   = 1'b0;
      o_e_Z     = 1'b0;
      o_e_PC    = 1'b0;
      o_e_MDR   = 1'b0;
      o_e_IR    = 1'b0;
      o_e_Y     = 1'b0;
      o_e_HI    = 1'b0;
      o_e_LO    = 1'b0;
      o_e_alu   = 1'b0;
      o_IncPC   = 1'b0;
      o_read    = 1'b0;
      o_alu_op  = '0;
      o_busy    = 1'b1;
      o_done    = 1'b0;
      o_illegal = 1'b0;
      s_r_en    = 1'b0;
      s_r_idx   = rb_w;
      e_r_en    = 1'b0;
      e_r_idx   = ra_w;

      unique case (state_q)
         ST_IDLE: begin
            o_busy = 1'b0;
         end
         ST_T0: begin
            o_s_PC  = 1'b1;
            o_e_MAR = 1'b1;
            o_IncPC = 1'b1;
            o_e_Z   = 1'b1;
         end
         ST_T1: begin
            o_s_Zlow = 1'b1;
            o_e_PC   = 1'b1;
            o_read   = 1'b1;
            o_e_MDR  = 1'b1;
         end
         ST_T1W: begin
            // Waiting on memory: keep the read and MDR capture going, but
            // the PC has already taken its incremented value.
            o_s_Zlow = 1'b1;
            o_read   = 1'b1;
            o_e_MDR  = 1'b1;
         end
         ST_T2: begin
            o_s_MDR = 1'b1;
            o_e_IR  = 1'b1;
         end
         ST_T3: begin
            // Rb stays on the bus either way; only Y's load is gated, so an
            // illegal op changes no DataPath register.
            s_r_en  = 1'b1;
            s_r_idx = rb_w;
            if (op_legal_w) begin
               o_e_Y = 1'b1;
            end else begin
               o_illegal = 1'b1;
            end
         end
         ST_T4: begin
            o_e_alu  = 1'b1;
            o_e_Z    = 1'b1;
            o_alu_op = OPW'(op_w);
            s_r_en   = 1'b1;
            s_r_idx  = op_unary_w ? rb_w : rc_w;
         end
         ST_T5: begin
            o_s_Zlow = 1'b1;
            if (op_muldiv_w) begin
               o_e_LO = 1'b1;
            end else begin
               e_r_en  = 1'b1;
               e_r_idx = ra_w;
               o_done  = 1'b1;
            end
         end
         ST_T6: begin
            o_s_Zhigh = 1'b1;
            o_e_HI    = 1'b1;
            o_done    = 1'b1;
         end
         ST_END: begin
            // All-zero cycle; o_busy remains high.
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // One-hot register select / enable. Indices with no matching register
   // simply produce no bit.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg_dec
         assign o_s_R[gi] = s_r_en && (int'(s_r_idx) == gi);
         assign o_e_R[gi] = e_r_en && (int'(e_r_idx) == gi);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer
// ----------------------------------------------------------------------------
// Directed, table-driven bench for control_sequencer. Each table record gives
// the inputs applied during one clock cycle and the complete output word the
// sequencer must present in that cycle. Hand-written sequences cover latency
// and reset in the middle of an instruction.
// ============================================================================
`timescale 1ns/1ps

module tb_control_sequencer;

   localparam int NREG = 16;
   localparam int OPW  = 6;

   logic            clk;
   logic            clr;
   logic            run;
   logic            rdy;
   logic            step;
   logic [31:0]     ir;

   logic            s_PC, s_Zlow, s_Zhigh, s_MDR;
   logic [NREG-1:0] s_R, e_R;
   logic            e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu;
   logic            IncPC, rd;
   logic [OPW-1:0]  alu_op;
   logic            busy, done, illegal;

   control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
      .w_clock     (clk),
      .w_clear     (clr),
      .i_run       (run),
      .i_mem_ready (rdy),
`ifdef SEQ_STEP_EN
      .i_step      (step),
`endif
      .i_IR        (ir),
      .o_s_PC      (s_PC),
      .o_s_Zlow    (s_Zlow),
      .o_s_Zhigh   (s_Zhigh),
      .o_s_MDR     (s_MDR),
      .o_s_R       (s_R),
      .o_e_R       (e_R),
      .o_e_MAR     (e_MAR),
      .o_e_Z       (e_Z),
      .o_e_PC      (e_PC),
      .o_e_MDR     (e_MDR),
      .o_e_IR      (e_IR),
      .o_e_Y       (e_Y),
      .o_e_HI      (e_HI),
      .o_e_LO      (e_LO),
      .o_e_alu     (e_alu),
      .o_IncPC     (IncPC),
      .o_read      (rd),
      .o_alu_op    (alu_op),
      .o_busy      (busy),
      .o_done      (done),
      .o_illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output word: bit 0 s_PC ... bit 55 e_R[15]
   logic [55:0] obs;
   assign obs = {e_R, s_R, alu_op, illegal, done, busy, rd, IncPC, e_alu,
                 e_LO, e_HI, e_Y, e_IR, e_MDR, e_PC, e_Z, e_MAR,
                 s_MDR, s_Zhigh, s_Zlow, s_PC};

   localparam logic [55:0] B_SPC    = 56'd1 << 0;
   localparam logic [55:0] B_SZLOW  = 56'd1 << 1;
   localparam logic [55:0] B_SZHIGH = 56'd1 << 2;
   localparam logic [55:0] B_SMDR   = 56'd1 << 3;
   localparam logic [55:0] B_EMAR   = 56'd1 << 4;
   localparam logic [55:0] B_EZ     = 56'd1 << 5;
   localparam logic [55:0] B_EPC    = 56'd1 << 6;
   localparam logic [55:0] B_EMDR   = 56'd1 << 7;
   localparam logic [55:0] B_EIR    = 56'd1 << 8;
   localparam logic [55:0] B_EY     = 56'd1 << 9;
   localparam logic [55:0] B_EHI    = 56'd1 << 10;
   localparam logic [55:0] B_ELO    = 56'd1 << 11;
   localparam logic [55:0] B_EALU   = 56'd1 << 12;
   localparam logic [55:0] B_INC    = 56'd1 << 13;
   localparam logic [55:0] B_READ   = 56'd1 << 14;
   localparam logic [55:0] B_BUSY   = 56'd1 << 15;
   localparam logic [55:0] B_DONE   = 56'd1 << 16;
   localparam logic [55:0] B_ILL    = 56'd1 << 17;

   localparam logic [55:0] O_IDLE = 56'd0;
   localparam logic [55:0] O_T0   = B_SPC | B_EMAR | B_INC | B_EZ | B_BUSY;
   localparam logic [55:0] O_T1   = B_SZLOW | B_EPC | B_READ | B_EMDR | B_BUSY;
   localparam logic [55:0] O_T1W  = B_SZLOW | B_READ | B_EMDR | B_BUSY;
   localparam logic [55:0] O_T2   = B_SMDR | B_EIR | B_BUSY;
   localparam logic [55:0] O_END  = B_BUSY;

   function automatic logic [55:0] sr(input int i);
      return 56'd1 << (24 + i);
   endfunction
   function automatic logic [55:0] er(input int i);
      return 56'd1 << (40 + i);
   endfunction
   function automatic logic [55:0] alu(input int v);
      return 56'(v) << 18;
   endfunction

   // Instruction words
   localparam logic [31:0] IR_MUL  = 32'h28918000; // mul R1,R2,R3
   localparam logic [31:0] IR_SHRA = 32'h50918000; // shra R1,R2,R3
   localparam logic [31:0] IR_I20  = 32'hA0000000; // op 20
   localparam logic [31:0] IR_NOT  = 32'h22BC8000; // not R5,R7 (Rc=9 ignored)
   localparam logic [31:0] IR_NEG  = 32'h67F00000; // neg R15,R14
   localparam logic [31:0] IR_I13  = 32'h68000000; // op 13
   localparam logic [31:0] IR_ADD  = 32'h00000000; // add R0,R0,R0

   typedef struct {
      logic        clr;
      logic        run;
      logic        rdy;
      logic [31:0] ir;
      logic [55:0] exp;
   } vec_t;

   vec_t vecs[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic add(input logic c, input logic r, input logic m,
                      input logic [31:0] w, input logic [55:0] e);
      vec_t v;
      v.clr = c; v.run = r; v.rdy = m; v.ir = w; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [55:0] act,
                        input logic [55:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Starting from IDLE at a negedge: run one instruction with i_run dropped
   // after T0, count busy cycles.
   task automatic measure(input string name, input logic [31:0] w,
                          input int waits, input int exp_cycles);
      int count;
      ir  = w;
      run = 1'b1;
      rdy = 1'b1;
      tick();
      run = 1'b0;
      count = 0;
      while (busy && count < 50) begin
         rdy = (count >= 1 + waits);
         count++;
         tick();
      end
      check(name, 56'(count), 56'(exp_cycles));
   endtask

   initial begin
      string nm;
      clr  = 1'b0;
      run  = 1'b0;
      rdy  = 1'b0;
      step = 1'b0;
      ir   = 32'd0;

      // mul: full fetch, then T3..T6, END, back to T0
      add(1, 0, 1, IR_MUL,  O_IDLE);
      add(1, 1, 1, IR_MUL,  O_IDLE);
      add(1, 1, 1, IR_MUL,  O_T0);
      add(1, 1, 1, IR_MUL,  O_T1);
      add(1, 1, 1, IR_MUL,  O_T2);
      add(1, 1, 1, IR_MUL,  sr(2) | B_EY | B_BUSY);
      add(1, 1, 1, IR_MUL,  B_EALU | B_EZ | alu(5) | sr(3) | B_BUSY);
      add(1, 1, 1, IR_MUL,  B_SZLOW | B_ELO | B_BUSY);
      add(1, 1, 1, IR_MUL,  B_SZHIGH | B_EHI | B_DONE | B_BUSY);
      add(1, 1, 1, IR_MUL,  O_END);
      // shra with three memory-wait cycles in T1
      add(1, 1, 1, IR_SHRA, O_T0);
      add(1, 1, 0, IR_SHRA, O_T1);
      add(1, 1, 0, IR_SHRA, O_T1W);
      add(1, 1, 0, IR_SHRA, O_T1W);
      add(1, 1, 1, IR_SHRA, O_T1W);
      add(1, 1, 1, IR_SHRA, O_T2);
      add(1, 1, 1, IR_SHRA, sr(2) | B_EY | B_BUSY);
      add(1, 1, 1, IR_SHRA, B_EALU | B_EZ | alu(10) | sr(3) | B_BUSY);
      add(1, 1, 1, IR_SHRA, B_SZLOW | er(1) | B_DONE | B_BUSY);
      add(1, 1, 1, IR_SHRA, O_END);
      // illegal op 20
      add(1, 1, 1, IR_I20,  O_T0);
      add(1, 1, 1, IR_I20,  O_T1);
      add(1, 1, 1, IR_I20,  O_T2);
      add(1, 1, 1, IR_I20,  sr(0) | B_ILL | B_BUSY);
      add(1, 1, 1, IR_I20,  O_END);
      // not (unary uses Rb in T4); i_run dropped in T4
      add(1, 1, 1, IR_NOT,  O_T0);
      add(1, 1, 1, IR_NOT,  O_T1);
      add(1, 1, 1, IR_NOT,  O_T2);
      add(1, 1, 1, IR_NOT,  sr(7) | B_EY | B_BUSY);
      add(1, 0, 1, IR_NOT,  B_EALU | B_EZ | alu(4) | sr(7) | B_BUSY);
      add(1, 0, 1, IR_NOT,  B_SZLOW | er(5) | B_DONE | B_BUSY);
      add(1, 0, 1, IR_NOT,  O_END);
      add(1, 0, 1, IR_NOT,  O_IDLE);
      add(1, 1, 1, IR_NEG,  O_IDLE);
      // neg: highest legal op, top register index
      add(1, 1, 1, IR_NEG,  O_T0);
      add(1, 1, 1, IR_NEG,  O_T1);
      add(1, 1, 1, IR_NEG,  O_T2);
      add(1, 1, 1, IR_NEG,  sr(14) | B_EY | B_BUSY);
      add(1, 1, 1, IR_NEG,  B_EALU | B_EZ | alu(12) | sr(14) | B_BUSY);
      add(1, 1, 1, IR_NEG,  B_SZLOW | er(15) | B_DONE | B_BUSY);
      add(1, 1, 1, IR_NEG,  O_END);
      // op 13: first illegal op
      add(1, 1, 1, IR_I13,  O_T0);
      add(1, 1, 1, IR_I13,  O_T1);
      add(1, 1, 1, IR_I13,  O_T2);
      add(1, 1, 1, IR_I13,  sr(0) | B_ILL | B_BUSY);
      add(1, 0, 1, IR_I13,  O_END);
      add(1, 0, 1, IR_I13,  O_IDLE);

      // Initial reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_idle", obs, O_IDLE);
      clr = 1'b1;

      // Table
      for (int i = 0; i < vecs.size(); i++) begin
         clr = vecs[i].clr;
         run = vecs[i].run;
         rdy = vecs[i].rdy;
         ir  = vecs[i].ir;
         #1;
         nm = $sformatf("vec%0d", i);
         check(nm, obs, vecs[i].exp);
         tick();
      end

      // Latency (state is IDLE here)
      measure("lat_add",      IR_ADD, 0, 7);
      measure("lat_mul",      IR_MUL, 0, 8);
      measure("lat_add_wait", IR_ADD, 2, 9);

      // Reset for two cycles while in T4
      ir  = IR_MUL;
      rdy = 1'b1;
      run = 1'b1;
      repeat (5) tick();
      check("pre_reset_T4", obs, B_EALU | B_EZ | alu(5) | sr(3) | B_BUSY);
      clr = 1'b0;
      tick();
      check("reset_mid_1", obs, O_IDLE);
      tick();
      check("reset_mid_2", obs, O_IDLE);
      clr = 1'b1;
      run = 1'b0;
      tick();
      check("after_reset", obs, O_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
